// File: rtl/reg_bank_cmd_pkg.sv
// reg_bank_cmd_pkg: shared definitions for the byte-command register bank.
// Holds the FSM state encoding, the command header field layout and the
// fixed command-path data width. Optional feature macro: CMD_BURST_EN.
package reg_bank_cmd_pkg;

  // The command path moves whole UART bytes, so register width is fixed.
  localparam int CMD_DATA_BITS = 8;

  // Header byte layout: {RW, LEN[6:0]}
  localparam int HDR_RW_BIT  = 7;
  localparam int HDR_LEN_MSB = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_RREAD = 3'd4,
    S_RSEND = 3'd5,
    S_RWAIT = 3'd6
  } state_t;

  // RW=1 selects a write command.
  function automatic logic hdrIsWrite(input logic [CMD_DATA_BITS-1:0] hdr);
    return hdr[HDR_RW_BIT];
  endfunction

  // Number of bytes to move is LEN+1, giving 1..128.
  function automatic logic [7:0] hdrCount(input logic [CMD_DATA_BITS-1:0] hdr);
    return {1'b0, hdr[HDR_LEN_MSB:0]} + 8'd1;
  endfunction

endpackage

// File: rtl/reg_bank_cmd_if.sv
// reg_bank_cmd_if: bundles the UART byte stream, the transmit handshake and
// the hardware-side register port. The controller is the slave side; the
// UART/ULPI logic (or a testbench) is the master side.
interface reg_bank_cmd_if #(
  parameter int ADDR_BITS = 6
);
  import reg_bank_cmd_pkg::*;

  logic [CMD_DATA_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic [CMD_DATA_BITS-1:0] tx_data;
  logic                     tx_send;
  logic                     tx_busy;
  logic                     hw_we;
  logic [ADDR_BITS-1:0]     hw_addr;
  logic [CMD_DATA_BITS-1:0] hw_wdata;
  logic [CMD_DATA_BITS-1:0] hw_rdata;
  logic                     busy;
  logic                     err_timeout;

  modport master (
    output rx_data, rx_valid, tx_busy, hw_we, hw_addr, hw_wdata,
    input  tx_data, tx_send, hw_rdata, busy, err_timeout
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy, hw_we, hw_addr, hw_wdata,
    output tx_data, tx_send, hw_rdata, busy, err_timeout
  );

endinterface

// File: rtl/reg_bank_dp.sv
// reg_bank_dp: 2^ADDR_BITS x 8 register array with a single write port
// shared by the hardware and command sides (hardware has priority) and two
// independent registered read ports.
module reg_bank_dp
  import reg_bank_cmd_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hw_we_i,
  input  logic [ADDR_BITS-1:0]     hw_waddr_i,
  input  logic [CMD_DATA_BITS-1:0] hw_wdata_i,
  input  logic                     cmd_we_i,
  input  logic [ADDR_BITS-1:0]     cmd_waddr_i,
  input  logic [CMD_DATA_BITS-1:0] cmd_wdata_i,
  input  logic [ADDR_BITS-1:0]     hw_raddr_i,
  output logic [CMD_DATA_BITS-1:0] hw_rdata_o,
  input  logic [ADDR_BITS-1:0]     cmd_raddr_i,
  output logic [CMD_DATA_BITS-1:0] cmd_rdata_o,
  output logic                     cmd_blocked_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [CMD_DATA_BITS-1:0] mem_q [DEPTH];
  logic                     wrEn;
  logic [ADDR_BITS-1:0]     wrAddr;
  logic [CMD_DATA_BITS-1:0] wrData;

  // Priority mux onto the single write port: a hardware write always wins,
  // and the command side is told so it can retry on the next cycle.
  always_comb begin
    wrEn          = hw_we_i | cmd_we_i;
    wrAddr        = hw_we_i ? hw_waddr_i : cmd_waddr_i;
    wrData        = hw_we_i ? hw_wdata_i : cmd_wdata_i;
    cmd_blocked_o = hw_we_i & cmd_we_i;
  end

  // Register array; cleared to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wrEn) begin
      mem_q[wrAddr] <= wrData;
    end
  end

  // Both read ports return the pre-write contents one cycle after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_rdata_o  <= '0;
      cmd_rdata_o <= '0;
    end else begin
      hw_rdata_o  <= mem_q[hw_raddr_i];
      cmd_rdata_o <= mem_q[cmd_raddr_i];
    end
  end

endmodule

// File: rtl/reg_bank_cmd.sv
// reg_bank_cmd: parses framed UART commands ({RW,LEN}, address, data...) and
// performs register reads/writes on a bank shared with the ULPI datapath.
// Optional feature macro: CMD_BURST_EN enables LEN-driven bursts with address
// auto-increment; without it every command moves exactly one byte.
module reg_bank_cmd
  import reg_bank_cmd_pkg::*;
#(
  parameter int ADDR_BITS      = 6,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic           clk,
  input logic           rst_n,
  reg_bank_cmd_if.slave bus
);

  if (DATA_BITS != CMD_DATA_BITS) begin : g_bad_data_bits
    $error("reg_bank_cmd: DATA_BITS must be 8 for the byte command path");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 8) begin : g_bad_addr_bits
    $error("reg_bank_cmd: ADDR_BITS must be within 1..8");
  end

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                   state_q;
  logic [ADDR_BITS-1:0]     addr_q;
  logic [ADDR_BITS-1:0]     rdAddr_d;
  logic                     rw_q;
  logic                     pend_q;
  logic [CMD_DATA_BITS-1:0] wdata_q;
  logic [CMD_DATA_BITS-1:0] tx_data_q;
  logic                     tx_send_q;
  logic                     err_q;
  logic [TMO_W-1:0]         tmo_q;
  logic                     cmdWe;
  logic                     cmdBlocked;
  logic [CMD_DATA_BITS-1:0] cmdWdata;
  logic [CMD_DATA_BITS-1:0] cmdRdata;
  logic                     timedState;
`ifdef CMD_BURST_EN
  logic [7:0]               count_q;
  logic                     lastXfer;
`endif

  // Command write request: a fresh data byte, or a retry of one that lost
  // the write port to the hardware side last cycle.
  always_comb begin
    cmdWe      = pend_q | ((state_q == S_WDATA) & bus.rx_valid);
    cmdWdata   = pend_q ? wdata_q : bus.rx_data;
    timedState = (state_q == S_HDR) | (state_q == S_ADDR) | (state_q == S_WDATA);
  end

`ifdef CMD_BURST_EN
  assign lastXfer = (count_q == 8'd1);

  // The read port is addressed one cycle ahead so RREAD sees the next byte.
  always_comb begin
    rdAddr_d = addr_q;
    if (state_q == S_RWAIT && !bus.tx_busy) begin
      rdAddr_d = addr_q + 1'b1;
    end
  end
`else
  assign rdAddr_d = addr_q;
`endif

  reg_bank_dp #(
    .ADDR_BITS(ADDR_BITS)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .hw_we_i      (bus.hw_we),
    .hw_waddr_i   (bus.hw_addr),
    .hw_wdata_i   (bus.hw_wdata),
    .cmd_we_i     (cmdWe),
    .cmd_waddr_i  (addr_q),
    .cmd_wdata_i  (cmdWdata),
    .hw_raddr_i   (bus.hw_addr),
    .hw_rdata_o   (bus.hw_rdata),
    .cmd_raddr_i  (rdAddr_d),
    .cmd_rdata_o  (cmdRdata),
    .cmd_blocked_o(cmdBlocked)
  );

  // Command FSM: header/address parsing, write bursts, read-and-send loop,
  // inter-byte timeout and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      pend_q    <= 1'b0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
`ifdef CMD_BURST_EN
      count_q   <= 8'd0;
`endif
    end else begin
      err_q <= 1'b0;
      if (timedState && !bus.rx_valid && !pend_q && tmo_q == TMO_LAST) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
        tmo_q   <= '0;
      end else begin
        if (bus.rx_valid || !timedState) begin
          tmo_q <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            if (bus.rx_valid) begin
              rw_q    <= hdrIsWrite(bus.rx_data);
`ifdef CMD_BURST_EN
              count_q <= hdrCount(bus.rx_data);
`endif
              state_q <= S_HDR;
            end
          end
          S_HDR: begin
            if (bus.rx_valid) begin
              addr_q  <= bus.rx_data[ADDR_BITS-1:0];
              state_q <= S_ADDR;
            end
          end
          S_ADDR: begin
            state_q <= rw_q ? S_WDATA : S_RREAD;
          end
          S_WDATA: begin
            if (cmdWe) begin
              if (cmdBlocked) begin
                pend_q  <= 1'b1;
                wdata_q <= cmdWdata;
              end else begin
                pend_q <= 1'b0;
`ifdef CMD_BURST_EN
                if (lastXfer) begin
                  state_q <= S_IDLE;
                end else begin
                  addr_q  <= addr_q + 1'b1;
                  count_q <= count_q - 8'd1;
                end
`else
                state_q <= S_IDLE;
`endif
              end
            end
          end
          S_RREAD: begin
            tx_data_q <= cmdRdata;
            tx_send_q <= !bus.tx_busy;
            state_q   <= S_RSEND;
          end
          S_RSEND: begin
            if (bus.tx_busy) begin
              tx_send_q <= 1'b0;
              state_q   <= S_RWAIT;
            end else begin
              tx_send_q <= 1'b1;
            end
          end
          S_RWAIT: begin
            if (!bus.tx_busy) begin
`ifdef CMD_BURST_EN
              if (lastXfer) begin
                state_q <= S_IDLE;
              end else begin
                addr_q  <= addr_q + 1'b1;
                count_q <= count_q - 8'd1;
                state_q <= S_RREAD;
              end
`else
              state_q <= S_IDLE;
`endif
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.err_timeout = err_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_bank_cmd.sv
// tb_reg_bank_cmd: directed scoreboard bench for reg_bank_cmd. Expected
// transmit bytes and hardware-port read values are queued by the stimulus
// and popped by independent monitors. Follows CMD_BURST_EN if defined.
module tb_reg_bank_cmd;

  localparam int ADDR_BITS      = 6;
  localparam int TIMEOUT_CYCLES = 100;
`ifdef CMD_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] value;
  } hwExp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic hwReq = 1'b0;
  logic txModelEn = 1'b1;
  int   assertCount = 0;
  int   failCount   = 0;
  logic [7:0] txExpQ[$];
  hwExp_t     hwExpQ[$];

  // Free-running controller clock.
  always #5 clk = ~clk;

  reg_bank_cmd_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  reg_bank_cmd #(
    .ADDR_BITS     (ADDR_BITS),
    .DATA_BITS     (8),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One UART byte on the rx strobe, followed by an inter-frame gap.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic hwWrite(input logic [5:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    bus.hw_we    = 1'b1;
    bus.hw_addr  = addr;
    bus.hw_wdata = data;
    @(posedge clk); #1;
    bus.hw_we = 1'b0;
  endtask

  task automatic pushHw(input string name, input logic [7:0] value);
    hwExp_t e;
    e.name  = name;
    e.value = value;
    hwExpQ.push_back(e);
  endtask

  task automatic hwRead(input string name, input logic [5:0] addr, input logic [7:0] exp);
    @(posedge clk); #1;
    bus.hw_addr = addr;
    pushHw(name, exp);
    hwReq = 1'b1;
    @(posedge clk); #1;
    hwReq = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int n = 0;
    while (bus.busy && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, bus.busy, 0);
  endtask

  task automatic waitErr(input string name, input int maxCycles, output int n);
    n = 0;
    while (!bus.err_timeout && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, bus.err_timeout, 1);
  endtask

  // UART transmitter model and tx scoreboard: accept a byte, hold tx_busy low
  // for two more cycles (tx_send must stay up), then stay busy five cycles.
  initial begin : txMonitor
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (txModelEn && rst_n && bus.tx_send && !bus.tx_busy) begin
        checkOutput("txExpected", (txExpQ.size() > 0), 1);
        if (txExpQ.size() > 0) begin
          checkOutput("txData", bus.tx_data, txExpQ.pop_front());
        end
        repeat (2) @(negedge clk);
        checkOutput("txSendHold", bus.tx_send, 1);
        @(posedge clk); #1;
        bus.tx_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Hardware read port scoreboard: data is due one cycle after the request.
  initial begin : hwMonitor
    hwExp_t e;
    forever begin
      @(posedge clk);
      if (hwReq) begin
        @(negedge clk);
        checkOutput("hwExpected", (hwExpQ.size() > 0), 1);
        if (hwExpQ.size() > 0) begin
          e = hwExpQ.pop_front();
          checkOutput(e.name, bus.hw_rdata, e.value);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int n;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.hw_we    = 1'b0;
    bus.hw_addr  = '0;
    bus.hw_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetTxSend", bus.tx_send, 0);
    checkOutput("resetTxData", bus.tx_data, 8'h00);
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetErr", bus.err_timeout, 0);
    checkOutput("resetHwRdata", bus.hw_rdata, 8'h00);

    $display("[TB] single write");
    applyStimulus(8'h80);
    checkOutput("busyAfterHeader", bus.busy, 1);
    applyStimulus(8'h05);
    applyStimulus(8'hA5);
    waitIdle("singleWriteIdle", 20);
    hwRead("reg5", 6'd5, 8'hA5);

    $display("[TB] read with wrap");
    hwWrite(6'd63, 8'h11);
    hwWrite(6'd0, 8'h22);
    txExpQ.push_back(8'h11);
    if (BURST) txExpQ.push_back(8'h22);
    applyStimulus(8'h01);
    applyStimulus(8'h3F);
    waitIdle("readIdle", 200);
    checkOutput("readTxDrained", txExpQ.size(), 0);

    $display("[TB] write collision");
    applyStimulus(8'h80);
    applyStimulus(8'h07);
    @(posedge clk); #1;
    bus.rx_data  = 8'h44;
    bus.rx_valid = 1'b1;
    bus.hw_we    = 1'b1;
    bus.hw_addr  = 6'd7;
    bus.hw_wdata = 8'h33;
    pushHw("collideBefore", 8'h00);
    hwReq = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.hw_we    = 1'b0;
    pushHw("collideHwWins", 8'h33);
    @(posedge clk); #1;
    pushHw("collideCmdRetry", 8'h44);
    @(posedge clk); #1;
    hwReq = 1'b0;
    waitIdle("collideIdle", 20);

    $display("[TB] timeout");
    applyStimulus(8'h80);
    waitErr("timeoutPulse", 200, n);
    checkOutput("timeoutNotEarly", (n >= 90), 1);
    checkOutput("timeoutBusy", bus.busy, 0);
    @(negedge clk);
    checkOutput("timeoutOnePulse", bus.err_timeout, 0);
    applyStimulus(8'h80);
    applyStimulus(8'h02);
    applyStimulus(8'h55);
    waitIdle("afterTimeoutIdle", 20);
    hwRead("reg2", 6'd2, 8'h55);

    $display("[TB] length field");
    applyStimulus(8'h83);
    applyStimulus(8'h10);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkOutput("lenStillBusy", bus.busy, 1);
    waitErr("lenTimeout", 200, n);
    hwRead("reg10", 6'h10, 8'h01);
    hwRead("reg11", 6'h11, BURST ? 8'h02 : 8'h00);

    $display("[TB] reset during read");
    hwWrite(6'd9, 8'h5A);
    txModelEn = 1'b0;
    applyStimulus(8'h00);
    applyStimulus(8'h09);
    n = 0;
    while (!bus.tx_send && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rstTxSendUp", bus.tx_send, 1);
    checkOutput("rstTxData", bus.tx_data, 8'h5A);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstTxSendAsync", bus.tx_send, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstTxDataClr", bus.tx_data, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    txModelEn = 1'b1;
    hwRead("rstReg5", 6'd5, 8'h00);
    hwRead("rstReg63", 6'd63, 8'h00);
    hwRead("rstReg9", 6'd9, 8'h00);
    hwRead("rstReg10", 6'h10, 8'h00);

    n = 0;
    while ((hwExpQ.size() > 0 || txExpQ.size() > 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hwQueueDrained", hwExpQ.size(), 0);
    checkOutput("txQueueDrained", txExpQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/reg_bank_cmd.md
# reg_bank_cmd

Byte-command controller owning a parametrised, dual-access register bank for the USB3300 sniffer. It parses a framed command stream from the UART receiver, performs single or burst register reads/writes, and returns read data through the UART transmitter handshake. A second, hardware-side port lets the ULPI datapath read and write the same registers concurrently. Sits between the UART module and the ULPI/SPI logic in the controller clock domain.

## Interface
- ADDR_BITS, 6, register address width; bank depth = 2^ADDR_BITS (1..8)
- DATA_BITS, 8, register width; fixed at 8 for the command path, checked at elaboration
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between bytes of one command
- clk  in  1  controller clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_send  out  1  transmit request, level
- tx_busy  in  1  UART transmit in progress
- hw_we  in  1  hardware-port write enable
- hw_addr  in  ADDR_BITS  hardware-port address
- hw_wdata  in  8  hardware-port write data
- hw_rdata  out  8  hardware-port read data, registered
- busy  out  1  command in progress (state != IDLE)
- err_timeout  out  1  one-cycle pulse on command abort

## Operation
- Frame: header byte {RW, LEN[6:0]}, address byte, then data. RW=1 write, RW=0 read. Transfer count = LEN+1 (1..128).
- Address byte: bits above ADDR_BITS ignored.
- States: IDLE -> HDR received -> ADDR -> (WDATA | RREAD -> RSEND -> RWAIT) -> IDLE.
- Write: each rx_valid in WDATA writes rx_data to current address, then address+1 mod 2^ADDR_BITS, count-1; count exhausted -> IDLE.
- Read: RREAD latches register[addr] into tx_data; RSEND raises tx_send while tx_busy low and holds it until tx_busy observed high; RWAIT waits for tx_busy low, then address+1, count-1, back to RREAD or IDLE.
- rx_valid in RREAD/RSEND/RWAIT: byte dropped.
- Timeout: counter cleared on every rx_valid; in HDR/ADDR/WDATA reaching TIMEOUT_CYCLES -> IDLE, err_timeout pulse. Read states never time out.
- Hardware port: hw_rdata = register[hw_addr] one cycle later. Same-cycle writes to same address: hw port wins, command write retried next cycle (FSM stalls one cycle; rx bytes cannot arrive faster than one UART frame).
- Reset: all outputs 0, state IDLE, registers 0x00. Reset mid-command discards it; tx_send drops immediately.

## Timing
- rx_valid of last write byte -> register updated at next clk edge; readable on hw_rdata one cycle after that.
- ADDR byte (read) -> tx_send high 2 cycles later if tx_busy low.
- Wrap: address 2^ADDR_BITS-1 + 1 -> 0.
- busy asserts the cycle after header rx_valid, deasserts the cycle after final write or final tx_busy fall.

## Configuration
- CMD_BURST_EN defined: LEN honoured as above.
- Not defined: LEN ignored, count forced to 1; no auto-increment logic generated.

## Structure
- Shared package: state encoding, header field positions (RW bit 7, LEN[6:0]), DATA_BITS=8 constant.
- Sub-module reg_bank_dp: 2^ADDR_BITS x 8 register array, one write port with priority mux, two registered read ports.

## Test plan
- Write single: 0x80, 0x05, 0xA5 -> register 5 = 0xA5; hw_addr=5 gives hw_rdata 0xA5 next cycle.
- Burst read with wrap (ADDR_BITS=6, CMD_BURST_EN): preload 63=0x11, 0=0x22; send 0x01, 0x3F -> tx bytes 0x11 then 0x22, each tx_send held until tx_busy high.
- Write collision: hw_we to 7 with 0x33 same cycle as command write 0x44 to 7 -> next-cycle value 0x33, then 0x44.
- Timeout (TIMEOUT_CYCLES=100): send 0x80 only, idle 100 cycles -> err_timeout pulse, busy 0, next 0x80,0x02,0x55 writes register 2.
- Burst disabled: send 0x83, 0x10, 0x01, 0x02 -> only register 0x10 = 0x01; 0x02 treated as new header.
- Reset mid-read while tx_send high -> tx_send 0 asynchronously, all registers 0x00, state IDLE.
